seq_loader: RTL and testbench
=============================

// Module: seq_loader
// PURPOSE
//  Writer side of the sequence memories that the alignment datapath reads during fill/traceback.
//  Accepts a byte stream of nucleotide characters over valid/ready: sequence A first, then B, each closed by in_last.
//  Encodes each character to a 3-bit symbol and writes it into the SeqA/SeqB RAMs at addresses 1..len.
//  Reports both lengths and a done/error status to the top-level controller before en_init is raised.
// PARAMETERS
//  N        128            max symbols per sequence
//  BitAddr  $clog2(N+1)    index width base; all index/length ports are [BitAddr:0]
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-low reset
//  start      in   1          1-cycle pulse: begin loading (honoured in IDLE/DONE/ERR only)
//  in_valid   in   1          in_data valid
//  in_data    in   8          ASCII character
//  in_last    in   1          qualifies in_data as last symbol of current sequence
//  in_ready   out  1          loader accepts in_data this cycle
//  we_a       out  1          SeqA RAM write enable
//  we_b       out  1          SeqB RAM write enable
//  addr       out  BitAddr+1  write address (shared by both RAMs)
//  wdata      out  3          encoded symbol
//  len_a      out  BitAddr+1  symbols written to A
//  len_b      out  BitAddr+1  symbols written to B
//  load_done  out  1          both sequences loaded; level
//  err        out  1          bad character or overflow; level
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; in_ready, we_a, we_b, load_done, err = 0; addr, wdata, len_a, len_b = 0.
//  States: IDLE -start-> LOAD_A; LOAD_A -accept with in_last-> LOAD_B; LOAD_B -accept with in_last-> DONE;
//          any LOAD -bad char or overflow-> ERR; DONE/ERR -start-> LOAD_A (lengths, flags cleared that cycle).
//  in_ready = 1 only in LOAD_A/LOAD_B; accept = in_valid & in_ready. No back-pressure beyond state.
//  Write latency 1: on accept, next cycle we_a (LOAD_A) or we_b (LOAD_B) = 1 for one cycle, addr = cnt+1, wdata = code.
//  Counter cnt resets to 0 on entering each LOAD state; len_x = cnt after each write.
//  Encoding: 'A'=3'd1, 'C'=3'd2, 'G'=3'd3, 'T'=3'd4; any other byte is bad -> ERR, no write, in_ready drops next cycle.
//  Overflow: accept of symbol N+1 (no in_last by symbol N) -> ERR, no write.
//  Symbol N with in_last: legal, len = N. Minimum length 1 (in_last on first symbol).
//  load_done rises the cycle after the final B write (i.e. together with DONE state); never with err.
//  start while in LOAD_A/LOAD_B: ignored. start and accept in same cycle in IDLE: data not accepted (in_ready=0).
//  Reset mid-load: everything returns to reset values; RAM contents undefined, lengths read 0.
//  Address 0 is never written (reserved for init row/column).
// CONFIGURATION
//  SEQ_LOADER_CASEFOLD_EN defined: 'a','c','g','t' also accepted and encoded as uppercase.
//  Not defined: lowercase bytes are bad characters -> ERR.
// STRUCTURE
//  Shared include nw_defs.vh: SYM_A/C/G/T codes, SYM_BAD marker, ASCII constants, state encodings.
//  One sub-module: nt_encoder (combinational, 8-bit char -> 3-bit code + valid; holds the CASEFOLD ifdef).
//  seq_loader holds FSM, counter, registered write port.
// TESTING
//  start, stream "ACGT"(last) then "GA"(last) -> we_a at addr 1..4 data 1,2,3,4; we_b addr 1,2 data 3,1; len_a=4, len_b=2, load_done=1.
//  A stream of N 'T' with last on Nth, B of 1 'C' -> len_a=N, addr reaches N, load_done=1, err=0.
//  A stream of N+1 'A' without last -> ERR on symbol N+1, exactly N writes, err=1, in_ready=0.
//  A = "AXG" -> ERR on 'X', only addr 1 written; with CASEFOLD_EN, "acg"(last) -> data 1,2,3 and no err.
//  rst pulsed low mid-B -> all outputs 0 immediately (async); start afterwards reloads A from addr 1.
//  in_valid toggled randomly with gaps; start pulsed during LOAD_B -> ignored, writes only on accepts, final lengths correct.

Source files
------------

// File: rtl/seq_loader_pkg.sv
// seq_loader_pkg
// Shared definitions for the sequence loader and its character encoder:
// the 3-bit nucleotide symbol codes, the ASCII bytes they come from, and
// the loader FSM state encoding.
// Ports: none (package only).
// Configuration macro: SEQ_LOADER_CASEFOLD_EN (used by nt_encoder only).

package seq_loader_pkg;

    // Symbol codes stored in the sequence RAMs. Code 0 is never written.
    // It doubles as the "no valid symbol" marker out of the encoder.
    localparam logic [2:0] SYM_BAD = 3'd0;
    localparam logic [2:0] SYM_A   = 3'd1;
    localparam logic [2:0] SYM_C   = 3'd2;
    localparam logic [2:0] SYM_G   = 3'd3;
    localparam logic [2:0] SYM_T   = 3'd4;

    // Uppercase nucleotide characters.
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_C = 8'h43;
    localparam logic [7:0] ASCII_G = 8'h47;
    localparam logic [7:0] ASCII_T = 8'h54;

    // Lowercase forms, only meaningful when case folding is compiled in.
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LC = 8'h63;
    localparam logic [7:0] ASCII_LG = 8'h67;
    localparam logic [7:0] ASCII_LT = 8'h74;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } load_state_t;

endpackage

// File: rtl/seq_loader_nt_encoder.sv
// nt_encoder
// Combinational translation of one ASCII byte into the 3-bit nucleotide
// symbol used by the alignment datapath.
// Ports:
//   in_char  in  8  ASCII character from the input stream
//   code     out 3  encoded symbol (SYM_BAD when not a nucleotide)
//   valid    out 1  in_char is an accepted nucleotide character
// Configuration:
//   SEQ_LOADER_CASEFOLD_EN defined  -> 'a','c','g','t' map like uppercase
//   SEQ_LOADER_CASEFOLD_EN undefined -> lowercase bytes are rejected

module nt_encoder
    import seq_loader_pkg::*;
(
    input  logic [7:0] in_char,
    output logic [2:0] code,
    output logic       valid
);

    // Table lookup from character to symbol. Anything not listed falls to
    // the default, which reports an invalid character so the loader can
    // abort the load instead of writing garbage into the RAM.
    always_comb begin
        code  = SYM_BAD;
        valid = 1'b0;
        case (in_char)
            ASCII_A: begin
                code  = SYM_A;
                valid = 1'b1;
            end
            ASCII_C: begin
                code  = SYM_C;
                valid = 1'b1;
            end
            ASCII_G: begin
                code  = SYM_G;
                valid = 1'b1;
            end
            ASCII_T: begin
                code  = SYM_T;
                valid = 1'b1;
            end
`ifdef SEQ_LOADER_CASEFOLD_EN
            ASCII_LA: begin
                code  = SYM_A;
                valid = 1'b1;
            end
            ASCII_LC: begin
                code  = SYM_C;
                valid = 1'b1;
            end
            ASCII_LG: begin
                code  = SYM_G;
                valid = 1'b1;
            end
            ASCII_LT: begin
                code  = SYM_T;
                valid = 1'b1;
            end
`endif
            default: begin
                code  = SYM_BAD;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_loader.sv
// seq_loader
// Writer side of the SeqA/SeqB memories. Takes a valid/ready byte stream
// holding sequence A then sequence B (each terminated by in_last), encodes
// each character and writes it to addresses 1..len of the matching RAM.
// Address 0 is reserved for the init row/column and is never written.
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-low reset
//   start      in   1          begin a load (honoured in IDLE/DONE/ERR)
//   in_valid   in   1          in_data valid
//   in_data    in   8          ASCII character
//   in_last    in   1          in_data is the last symbol of this sequence
//   in_ready   out  1          loader accepts in_data this cycle
//   we_a       out  1          SeqA RAM write enable
//   we_b       out  1          SeqB RAM write enable
//   addr       out  BitAddr+1  shared write address
//   wdata      out  3          encoded symbol
//   len_a      out  BitAddr+1  symbols written to A
//   len_b      out  BitAddr+1  symbols written to B
//   load_done  out  1          both sequences loaded (level)
//   err        out  1          bad character or overflow (level)
// Configuration macro: SEQ_LOADER_CASEFOLD_EN (lowercase acceptance,
// implemented inside nt_encoder).

module seq_loader
    import seq_loader_pkg::*;
#(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             we_a,
    output logic             we_b,
    output logic [BitAddr:0] addr,
    output logic [2:0]       wdata,
    output logic [BitAddr:0] len_a,
    output logic [BitAddr:0] len_b,
    output logic             load_done,
    output logic             err
);

    localparam logic [BitAddr:0] CntMax = (BitAddr + 1)'(N);

    load_state_t      state;
    logic [BitAddr:0] cnt;
    logic [BitAddr:0] cnt_next;
    logic [2:0]       sym_code;
    logic             sym_valid;
    logic             accept;

    nt_encoder u_encoder (
        .in_char (in_data),
        .code    (sym_code),
        .valid   (sym_valid)
    );

    // A byte is consumed only when the loader is in a LOAD state (in_ready
    // is a registered copy of that) and the source offers it. cnt_next is
    // both the address of the symbol being written and the new length.
    always_comb begin
        accept   = in_valid & in_ready;
        cnt_next = cnt + 1'b1;
    end

    // Single FSM owning the counter and the registered write port.
    // Write enables are one-cycle pulses and default low every cycle.
    // A bad character or a symbol beyond N moves straight to ERR without
    // writing; cnt == N at accept time means this would be symbol N+1.
    // On the closing symbol of A the counter restarts for B; the closing
    // symbol of B raises load_done together with its own write pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            we_a      <= 1'b0;
            we_b      <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            len_a     <= '0;
            len_b     <= '0;
            load_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            we_a <= 1'b0;
            we_b <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state     <= ST_LOAD_A;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        len_a     <= '0;
                        len_b     <= '0;
                        load_done <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    if (accept) begin
                        if (!sym_valid || (cnt == CntMax)) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            addr  <= cnt_next;
                            wdata <= sym_code;
                            if (state == ST_LOAD_A) begin
                                we_a  <= 1'b1;
                                len_a <= cnt_next;
                            end else begin
                                we_b  <= 1'b1;
                                len_b <= cnt_next;
                            end
                            if (in_last) begin
                                cnt <= '0;
                                if (state == ST_LOAD_A) begin
                                    state <= ST_LOAD_B;
                                end else begin
                                    state     <= ST_DONE;
                                    in_ready  <= 1'b0;
                                    load_done <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt_next;
                            end
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_loader.sv
// tb_seq_loader
// Directed bench for seq_loader with the default N = 128.
// Ports: none (top-level bench).
// Honours SEQ_LOADER_CASEFOLD_EN to choose the lowercase expectations.

module tb_seq_loader;

    localparam int N       = 128;
    localparam int BitAddr = $clog2(N + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             we_a;
    logic             we_b;
    logic [BitAddr:0] addr;
    logic [2:0]       wdata;
    logic [BitAddr:0] len_a;
    logic [BitAddr:0] len_b;
    logic             load_done;
    logic             err;

    int n_total;
    int n_pass;

    // Write log filled from the DUT write port.
    int wa_data [512];
    int wb_data [512];
    int wa_count;
    int wb_count;
    int wa_max_addr;
    int addr0_hits;

    seq_loader #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .we_a      (we_a),
        .we_b      (we_b),
        .addr      (addr),
        .wdata     (wdata),
        .len_a     (len_a),
        .len_b     (len_b),
        .load_done (load_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write pulse mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (we_a) begin
                wa_data[int'(addr)] = int'(wdata);
                wa_count++;
                if (int'(addr) > wa_max_addr) wa_max_addr = int'(addr);
            end
            if (we_b) begin
                wb_data[int'(addr)] = int'(wdata);
                wb_count++;
            end
            if ((we_a || we_b) && addr == '0) addr0_hits++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic clear_log();
        for (int i = 0; i < 512; i++) begin
            wa_data[i] = -1;
            wb_data[i] = -1;
        end
        wa_count    = 0;
        wb_count    = 0;
        wa_max_addr = 0;
        addr0_hits  = 0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer one byte and hold it until accepted, with a bounded wait.
    task automatic apply_stimulus(input logic [7:0] c, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = c;
        in_last  = last;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_total++;
            $error("[TB] FAIL accept_timeout: in_ready observed 0 expected 1 for byte %0h", c);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_string(input string s, input logic last_at_end, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
            apply_stimulus(s[i], last_at_end && (i == s.len() - 1));
        end
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        clear_log();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready",  32'(in_ready),  0);
        check_output("rst_we",        32'(we_a | we_b), 0);
        check_output("rst_addr",      32'(addr),      0);
        check_output("rst_wdata",     32'(wdata),     0);
        check_output("rst_len_a",     32'(len_a),     0);
        check_output("rst_load_done", 32'(load_done), 0);
        check_output("rst_err",       32'(err),       0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Start together with valid data in IDLE: the byte is not taken
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = "G";
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_output("start_in_ready", 32'(in_ready), 1);
        check_output("start_no_write", 32'(we_a), 0);

        // Basic load: A = "ACGT", B = "GA"
        send_string("ACGT", 1'b1, 0);
        apply_stimulus("G", 1'b0);
        apply_stimulus("A", 1'b1);
        check_output("basic_done_with_we_b", 32'(load_done), 1);
        @(negedge clk);
        #1;
        check_output("basic_wa_count", 32'(wa_count), 4);
        check_output("basic_a1", 32'(wa_data[1]), 1);
        check_output("basic_a2", 32'(wa_data[2]), 2);
        check_output("basic_a3", 32'(wa_data[3]), 3);
        check_output("basic_a4", 32'(wa_data[4]), 4);
        check_output("basic_wb_count", 32'(wb_count), 2);
        check_output("basic_b1", 32'(wb_data[1]), 3);
        check_output("basic_b2", 32'(wb_data[2]), 1);
        check_output("basic_len_a", 32'(len_a), 4);
        check_output("basic_len_b", 32'(len_b), 2);
        check_output("basic_load_done", 32'(load_done), 1);
        check_output("basic_err", 32'(err), 0);
        check_output("basic_in_ready", 32'(in_ready), 0);

        // Restart from DONE clears lengths; A of N 'T', B of one 'C'
        clear_log();
        pulse_start();
        check_output("restart_len_a", 32'(len_a), 0);
        check_output("restart_load_done", 32'(load_done), 0);
        for (int i = 0; i < N; i++) apply_stimulus("T", i == N - 1);
        apply_stimulus("C", 1'b1);
        @(negedge clk);
        #1;
        check_output("full_len_a", 32'(len_a), N);
        check_output("full_max_addr", 32'(wa_max_addr), N);
        check_output("full_wa_count", 32'(wa_count), N);
        check_output("full_a_last", 32'(wa_data[N]), 4);
        check_output("full_len_b", 32'(len_b), 1);
        check_output("full_load_done", 32'(load_done), 1);
        check_output("full_err", 32'(err), 0);

        // Overflow: N+1 'A' without in_last
        clear_log();
        pulse_start();
        for (int i = 0; i < N + 1; i++) apply_stimulus("A", 1'b0);
        check_output("ovf_err", 32'(err), 1);
        check_output("ovf_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        #1;
        check_output("ovf_wa_count", 32'(wa_count), N);
        check_output("ovf_max_addr", 32'(wa_max_addr), N);
        check_output("ovf_len_a", 32'(len_a), N);
        check_output("ovf_load_done", 32'(load_done), 0);

        // Bad character: A = "AX" (G would never be accepted)
        clear_log();
        pulse_start();
        check_output("bad_err_cleared", 32'(err), 0);
        apply_stimulus("A", 1'b0);
        apply_stimulus("X", 1'b0);
        check_output("bad_err", 32'(err), 1);
        check_output("bad_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        #1;
        check_output("bad_wa_count", 32'(wa_count), 1);
        check_output("bad_a1", 32'(wa_data[1]), 1);
        check_output("bad_len_a", 32'(len_a), 1);

        // Lowercase input
        clear_log();
        pulse_start();
`ifdef SEQ_LOADER_CASEFOLD_EN
        send_string("acg", 1'b1, 0);
        apply_stimulus("t", 1'b1);
        @(negedge clk);
        #1;
        check_output("lc_a1", 32'(wa_data[1]), 1);
        check_output("lc_a2", 32'(wa_data[2]), 2);
        check_output("lc_a3", 32'(wa_data[3]), 3);
        check_output("lc_b1", 32'(wb_data[1]), 4);
        check_output("lc_err", 32'(err), 0);
        check_output("lc_load_done", 32'(load_done), 1);
`else
        apply_stimulus("a", 1'b1);
        @(negedge clk);
        #1;
        check_output("lc_err", 32'(err), 1);
        check_output("lc_wa_count", 32'(wa_count), 0);
`endif

        // Asynchronous reset in the middle of B
        clear_log();
        pulse_start();
        send_string("AC", 1'b1, 0);
        apply_stimulus("G", 1'b0);
        check_output("mid_we_b", 32'(we_b), 1);
        #3;
        rst = 1'b0;
        #1;
        check_output("arst_we_b", 32'(we_b), 0);
        check_output("arst_in_ready", 32'(in_ready), 0);
        check_output("arst_addr", 32'(addr), 0);
        check_output("arst_wdata", 32'(wdata), 0);
        check_output("arst_len_a", 32'(len_a), 0);
        check_output("arst_len_b", 32'(len_b), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        pulse_start();
        apply_stimulus("T", 1'b1);
        apply_stimulus("A", 1'b1);
        @(negedge clk);
        #1;
        check_output("reload_a1", 32'(wa_data[1]), 4);
        check_output("reload_b1", 32'(wb_data[1]), 1);
        check_output("reload_len_a", 32'(len_a), 1);
        check_output("reload_len_b", 32'(len_b), 1);
        check_output("reload_done", 32'(load_done), 1);

        // Gapped stream with a stray start during B
        clear_log();
        pulse_start();
        send_string("GATC", 1'b1, 3);
        apply_stimulus("C", 1'b0);
        idle_cycles(2);
        pulse_start();
        check_output("gap_start_ignored_ready", 32'(in_ready), 1);
        check_output("gap_start_ignored_len_a", 32'(len_a), 4);
        send_string("AG", 1'b1, 3);
        @(negedge clk);
        #1;
        check_output("gap_wa_count", 32'(wa_count), 4);
        check_output("gap_a1", 32'(wa_data[1]), 3);
        check_output("gap_a2", 32'(wa_data[2]), 1);
        check_output("gap_a3", 32'(wa_data[3]), 4);
        check_output("gap_a4", 32'(wa_data[4]), 2);
        check_output("gap_wb_count", 32'(wb_count), 3);
        check_output("gap_b1", 32'(wb_data[1]), 2);
        check_output("gap_b2", 32'(wb_data[2]), 1);
        check_output("gap_b3", 32'(wb_data[3]), 3);
        check_output("gap_len_a", 32'(len_a), 4);
        check_output("gap_len_b", 32'(len_b), 3);
        check_output("gap_done", 32'(load_done), 1);
        check_output("gap_err", 32'(err), 0);
        check_output("addr0_never_written", 32'(addr0_hits), 0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
